mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

- Shares the single synchronous memory port of the multicycle MIPS core between two requesters: port 0 is the control FSM's fetch/load/store path, port 1 is the program loader/DMA.
- Sequences each access as grant → issue → wait read latency → return data, one access in flight at a time.
- Sits between the datapath's memory address/data muxes and the memory primitive.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width
- `MEM_LAT`, 1, memory read latency in cycles, legal 1..4

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset (asserted when 0)
- `req0` / `req1`  in  1  access request, port 0 / port 1
- `we0` / `we1`  in  1  1 = write, 0 = read
- `addr0` / `addr1`  in  AW  access address
- `wdata0` / `wdata1`  in  DW  write data
- `gnt0` / `gnt1`  out  1  one-cycle grant pulse, registered
- `rvalid0` / `rvalid1`  out  1  one-cycle read-data-valid pulse, registered
- `rdata0` / `rdata1`  out  DW  read data, held until the port's next read completes
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory read data, valid `MEM_LAT` cycles after the issuing edge
- `busy`  out  1  1 whenever state ≠ IDLE

## Operation
State machine: IDLE, ISSUE, WAIT.

IDLE
- Outputs: `mem_en`=0, `mem_we`=0.
- If either `req` is high, select a winner and register `owner`, `we`, `addr` and `wdata` from the winner. Go to ISSUE.
- If no request, stay in IDLE.

ISSUE (exactly one cycle)
- Outputs: `gnt<owner>`=1, `mem_en`=1, `mem_we`=latched `we`, `mem_addr`/`mem_wdata` = latched values.
- Write: next state is IDLE. The write commits at the edge ending ISSUE.
- Read: load the wait counter with `MEM_LAT`-1 and go to WAIT.

WAIT
- Outputs: `mem_en`=0, `mem_we`=0.
- Decrement the counter each cycle.
- When the counter is 0: capture `mem_rdata` into `rdata<owner>`, set `rvalid<owner>`=1 for the next cycle, and go to IDLE.

Other rules
- The losing requester keeps `req` high and is served on a later IDLE cycle. Requests are never dropped.
- A requester must deassert `req` in the cycle after it sees its `gnt`. A `req` still high in IDLE is a new access.
- `mem_addr`/`mem_wdata` keep their last values outside ISSUE. Only `mem_en`/`mem_we` qualify them.
- `AW`/`DW` pass straight through, with no width conversion.
- Reset (any state, including mid-read) has the same effect:
  - State goes to IDLE.
  - All outputs go to 0, including `rdata0`/`rdata1`, `mem_addr` and `mem_wdata`.
  - The in-flight read is abandoned and no `rvalid` is produced.
  - The round-robin pointer is set so that port 0 wins first.

## Timing
- Request sampled in IDLE at edge E. ISSUE, with `gnt` and `mem_en`, occupies the cycle after E.
- Write service time: 2 cycles (IDLE sample + ISSUE). The next request can be sampled in the cycle right after ISSUE.
- Read: `rvalid` is high `MEM_LAT`+1 cycles after the ISSUE cycle. With `MEM_LAT`=1: ISSUE at cycle 1, WAIT at cycle 2, `rvalid` at cycle 3.
- The `rvalid` cycle is an IDLE cycle, so back-to-back reads run every `MEM_LAT`+2 cycles.
- `gnt0`/`gnt1` are never high together; likewise `rvalid0`/`rvalid1`.
- `busy` is high in ISSUE and WAIT and low in IDLE, including the `rvalid` cycle.

## Configuration
Macro: `ARB_ROUND_ROBIN_EN`.
- Defined: round-robin arbitration.
  - When both ports request in IDLE, the port not granted most recently wins.
  - The pointer updates on every grant.
  - After reset, port 0 wins the first tie.
- Undefined: fixed priority. Port 0 always wins a tie, the pointer logic is absent, and port 1 can starve.

## Test plan
- Reset mid-WAIT:
  - Stimulus: `rst`=0 while a port-0 read is in WAIT.
  - Response: next cycle state is IDLE, `busy`=0 and all outputs are 0. After release, no `rvalid0` ever appears for the dropped read.
- Single write:
  - Stimulus: `req0`=1, `we0`=1, `addr0`=0x10, `wdata0`=0xDEADBEEF.
  - Response: in the next cycle `gnt0`=1, `mem_en`=1, `mem_we`=1, `mem_addr`=0x10, `mem_wdata`=0xDEADBEEF. `busy` drops the cycle after.
- Single read, `MEM_LAT`=2:
  - Stimulus: `req1`=1, `we1`=0, `addr1`=0x40; memory returns 0x12345678.
  - Response: `gnt1` at cycle 1; `rvalid1`=1 with `rdata1`=0x12345678 at cycle 4; `rdata1` holds afterward.
- Tie, round-robin enabled:
  - Stimulus: `req0` and `req1` held high for 3 accesses.
  - Response: grants go port 0, port 1, port 0.
  - Same stimulus without the macro: port 0, port 0, port 0.
- Back-to-back reads, `MEM_LAT`=1:
  - Stimulus: port 0 re-requests in each `rvalid` cycle.
  - Response: `gnt0` every 3 cycles; `mem_en` never high in WAIT.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous memory port between two requesters
// (port 0 = core fetch/load/store, port 1 = loader/DMA). One access is in flight
// at a time: IDLE samples requests, ISSUE drives the memory for one cycle and
// pulses the grant, and WAIT counts out the read latency before returning data.
// Optional feature macro: ARB_ROUND_ROBIN_EN selects round-robin arbitration;
// when it is undefined, port 0 has fixed priority.
`timescale 1ns/1ps

module mem_port_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    // Wait counter holds MEM_LAT-1, and MEM_LAT is at most 4
    localparam int unsigned   CW       = 2;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]    r_state,     w_state_nxt;
    logic          r_owner,     w_owner_nxt;
    logic          r_we,        w_we_nxt;
    logic [CW-1:0] r_cnt,       w_cnt_nxt;
    logic          r_gnt0,      w_gnt0_nxt;
    logic          r_gnt1,      w_gnt1_nxt;
    logic          r_rvalid0,   w_rvalid0_nxt;
    logic          r_rvalid1,   w_rvalid1_nxt;
    logic [DW-1:0] r_rdata0,    w_rdata0_nxt;
    logic [DW-1:0] r_rdata1,    w_rdata1_nxt;
    logic          r_mem_en,    w_mem_en_nxt;
    logic          r_mem_we,    w_mem_we_nxt;
    logic [AW-1:0] r_mem_addr,  w_mem_addr_nxt;
    logic [DW-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic          r_busy,      w_busy_nxt;

    logic          w_any_req;
    logic          w_pick1;

    assign w_any_req = req0 | req1;

`ifdef ARB_ROUND_ROBIN_EN
    // Port granted most recently; reset value 1 makes port 0 win the first tie
    logic r_last;

    // Winner select: on a tie, the port not granted most recently wins
    always_comb begin
        w_pick1 = req1 & (~req0 | ~r_last);
    end

    // Pointer follows every grant made in IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last <= 1'b1;
        end else if (r_state == S_IDLE && w_any_req) begin
            r_last <= w_pick1;
        end
    end
`else
    // Winner select: port 0 always wins a tie
    always_comb begin
        w_pick1 = req1 & ~req0;
    end
`endif

    // State and registered-output register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_owner     <= 1'b0;
            r_we        <= 1'b0;
            r_cnt       <= '0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_rvalid0   <= 1'b0;
            r_rvalid1   <= 1'b0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_we        <= w_we_nxt;
            r_cnt       <= w_cnt_nxt;
            r_gnt0      <= w_gnt0_nxt;
            r_gnt1      <= w_gnt1_nxt;
            r_rvalid0   <= w_rvalid0_nxt;
            r_rvalid1   <= w_rvalid1_nxt;
            r_rdata0    <= w_rdata0_nxt;
            r_rdata1    <= w_rdata1_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Next state and next values of the registered outputs
    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_we_nxt        = r_we;
        w_cnt_nxt       = r_cnt;
        w_gnt0_nxt      = 1'b0;
        w_gnt1_nxt      = 1'b0;
        w_rvalid0_nxt   = 1'b0;
        w_rvalid1_nxt   = 1'b0;
        w_rdata0_nxt    = r_rdata0;
        w_rdata1_nxt    = r_rdata1;
        w_mem_en_nxt    = 1'b0;
        w_mem_we_nxt    = 1'b0;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;

        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    // The memory address/data registers double as the latched access
                    w_state_nxt     = S_ISSUE;
                    w_owner_nxt     = w_pick1;
                    w_we_nxt        = w_pick1 ? we1 : we0;
                    w_gnt0_nxt      = ~w_pick1;
                    w_gnt1_nxt      = w_pick1;
                    w_mem_en_nxt    = 1'b1;
                    w_mem_we_nxt    = w_pick1 ? we1 : we0;
                    w_mem_addr_nxt  = w_pick1 ? addr1 : addr0;
                    w_mem_wdata_nxt = w_pick1 ? wdata1 : wdata0;
                end
            end
            S_ISSUE: begin
                if (r_we) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                    if (r_owner) begin
                        w_rdata1_nxt  = mem_rdata;
                        w_rvalid1_nxt = 1'b1;
                    end else begin
                        w_rdata0_nxt  = mem_rdata;
                        w_rvalid0_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign rvalid0   = r_rvalid0;
    assign rvalid1   = r_rvalid1;
    assign rdata0    = r_rdata0;
    assign rdata1    = r_rdata1;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a latency-accurate memory model, a grant/read-data
// scoreboard checked on every falling edge, and one task per scenario.
`timescale 1ns/1ps

module tb_mem_port_arbiter;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned LAT = 2;
    localparam int          TMO = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct packed {
        logic          port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } gexp_t;

    typedef struct packed {
        logic          port;
        logic [DW-1:0] data;
    } rexp_t;

    gexp_t exp_g[$];
    rexp_t exp_r[$];
    gexp_t ge;
    rexp_t re;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: writes commit at the issuing edge; read data is valid LAT cycles
    // after it and is poisoned otherwise so a mistimed capture is visible
    logic [DW-1:0] mem_model [0:63];
    logic [DW-1:0] rd_pipe   [0:LAT-1];
    assign mem_rdata = rd_pipe[LAT-1];

    always @(posedge clk) begin
        if (mem_en && mem_we) mem_model[mem_addr[7:2]] <= mem_wdata;
        rd_pipe[0] <= (mem_en && !mem_we) ? mem_model[mem_addr[7:2]] : 32'hBAD0_BAD0;
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    // Scoreboard and protocol invariants, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            total++;
            if ((gnt0 & gnt1) !== 1'b0 || (rvalid0 & rvalid1) !== 1'b0) begin
                bad++;
                $display("FAIL onehot: gnt=%b%b rvalid=%b%b, required at most one of each", gnt1, gnt0, rvalid1, rvalid0);
            end
            total++;
            if (mem_en !== (gnt0 | gnt1)) begin
                bad++;
                $display("FAIL mem_en_qual: mem_en=%b gnt=%b%b, required mem_en only with a grant", mem_en, gnt1, gnt0);
            end
            if (gnt0 || gnt1) begin
                total++;
                if (exp_g.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_grant: gnt=%b%b at cycle %0d, required none", gnt1, gnt0, cyc);
                end else begin
                    ge = exp_g.pop_front();
                    if ({gnt1, mem_we, mem_addr, mem_wdata} !== {ge.port, ge.we, ge.addr, ge.wdata}) begin
                        bad++;
                        $display("FAIL grant_sb: port=%b we=%b addr=%h wdata=%h, required port=%b we=%b addr=%h wdata=%h",
                                 gnt1, mem_we, mem_addr, mem_wdata, ge.port, ge.we, ge.addr, ge.wdata);
                    end
                end
            end
            if (rvalid0 || rvalid1) begin
                total++;
                if (exp_r.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_rvalid: rvalid=%b%b at cycle %0d, required none", rvalid1, rvalid0, cyc);
                end else begin
                    re = exp_r.pop_front();
                    if ({rvalid1, (rvalid1 ? rdata1 : rdata0)} !== {re.port, re.data}) begin
                        bad++;
                        $display("FAIL rdata_sb: port=%b data=%h, required port=%b data=%h",
                                 rvalid1, (rvalid1 ? rdata1 : rdata0), re.port, re.data);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    // Returns the granted port, or -1 if no grant arrives within TMO cycles
    task automatic wait_gnt(output int port);
        port = -1;
        for (int i = 0; i < TMO; i++) begin
            @(posedge clk); #1;
            if (gnt0) begin port = 0; break; end
            if (gnt1) begin port = 1; break; end
        end
    endtask

    task automatic test_reset();
        int p;
        int seen;
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, busy} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctrl: %b, required 0000000", {gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, busy});
        end
        total++;
        if ({rdata0, rdata1, mem_addr, mem_wdata} !== 128'b0) begin
            bad++;
            $display("FAIL reset_data: rdata0=%h rdata1=%h addr=%h wdata=%h, required all 0", rdata0, rdata1, mem_addr, mem_wdata);
        end
        rst = 1'b1;
        @(posedge clk); #1;

        // A completed read leaves rdata0 non-zero so its reset is observable
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h40; wdata0 = 32'h5555_AAAA;
        exp_g.push_back(gexp_t'{port: 1'b0, we: 1'b0, addr: 32'h40, wdata: 32'h5555_AAAA});
        exp_r.push_back(rexp_t'{port: 1'b0, data: 32'h1234_5678});
        wait_gnt(p);
        req0 = 1'b0;
        total++;
        if (p != 0) begin bad++; $display("FAIL rst_pre_gnt: port=%0d, required 0", p); end
        repeat (LAT + 1) @(posedge clk);
        #1;
        total++;
        if ({rvalid0, rdata0} !== {1'b1, 32'h1234_5678}) begin
            bad++;
            $display("FAIL rst_pre_read: rvalid0=%b rdata0=%h, required 1 12345678", rvalid0, rdata0);
        end

        // Second read is abandoned by reset in WAIT
        req0 = 1'b1; addr0 = 32'h44; wdata0 = 32'h0BAD_F00D;
        exp_g.push_back(gexp_t'{port: 1'b0, we: 1'b0, addr: 32'h44, wdata: 32'h0BAD_F00D});
        wait_gnt(p);
        req0 = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({busy, mem_en} !== 2'b10) begin
            bad++;
            $display("FAIL rst_in_wait: busy=%b mem_en=%b, required 1 0", busy, mem_en);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, busy} !== 7'b0 ||
            {rdata0, rdata1, mem_addr, mem_wdata} !== 128'b0) begin
            bad++;
            $display("FAIL midwait_reset: ctrl=%b rdata0=%h addr=%h wdata=%h, required all 0",
                     {gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, busy}, rdata0, mem_addr, mem_wdata);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < LAT + 4; i++) begin
            @(posedge clk); #1;
            if (rvalid0 || rvalid1 || busy) seen++;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL dropped_read: activity cycles=%0d, required 0", seen); end
    endtask

    task automatic test_tie();
        int p;
        int order [3];
        int last_cyc;
        int port_of [2];
        logic [AW-1:0] a_of [2];
        logic [DW-1:0] d_of [2];
`ifdef ARB_ROUND_ROBIN_EN
        order[0] = 0; order[1] = 1; order[2] = 0;
`else
        order[0] = 0; order[1] = 0; order[2] = 0;
`endif
        port_of[0] = 0; port_of[1] = 1;
        a_of[0] = 32'h80; a_of[1] = 32'h84;
        d_of[0] = 32'hA0A0_0001; d_of[1] = 32'hB1B1_0002;
        last_cyc = 0;
        for (int k = 0; k < 3; k++)
            exp_g.push_back(gexp_t'{port: 1'(port_of[order[k]]), we: 1'b1, addr: a_of[order[k]], wdata: d_of[order[k]]});
        req0 = 1'b1; we0 = 1'b1; addr0 = a_of[0]; wdata0 = d_of[0];
        req1 = 1'b1; we1 = 1'b1; addr1 = a_of[1]; wdata1 = d_of[1];
        for (int k = 0; k < 3; k++) begin
            wait_gnt(p);
            if (k == 2) begin req0 = 1'b0; req1 = 1'b0; end
            total++;
            if (p != order[k]) begin bad++; $display("FAIL tie_order[%0d]: port=%0d, required %0d", k, p, order[k]); end
            if (k > 0) begin
                total++;
                if (cyc - last_cyc != 2) begin bad++; $display("FAIL write_period[%0d]: %0d cycles, required 2", k, cyc - last_cyc); end
            end
            last_cyc = cyc;
        end
        idle_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_single_write();
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h10; wdata0 = 32'hDEAD_BEEF;
        exp_g.push_back(gexp_t'{port: 1'b0, we: 1'b1, addr: 32'h10, wdata: 32'hDEAD_BEEF});
        @(posedge clk); #1;
        req0 = 1'b0;
        total++;
        if ({gnt0, gnt1, mem_en, mem_we, busy, mem_addr, mem_wdata} !== {5'b10111, 32'h10, 32'hDEAD_BEEF}) begin
            bad++;
            $display("FAIL write_issue: gnt=%b%b en=%b we=%b busy=%b addr=%h wdata=%h, required 10 1 1 1 00000010 deadbeef",
                     gnt0, gnt1, mem_en, mem_we, busy, mem_addr, mem_wdata);
        end
        @(posedge clk); #1;
        total++;
        if ({gnt0, mem_en, mem_we, busy, mem_addr} !== {4'b0000, 32'h10}) begin
            bad++;
            $display("FAIL write_done: gnt0=%b en=%b we=%b busy=%b addr=%h, required 0 0 0 0 00000010",
                     gnt0, mem_en, mem_we, busy, mem_addr);
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        int p;
        int n;
        int last_cyc;
        logic [AW-1:0] a [3];
        logic [DW-1:0] d [3];
        a[0] = 32'h40; d[0] = 32'h1234_5678;
        a[1] = 32'h80; d[1] = 32'hA0A0_0001;
        a[2] = 32'h10; d[2] = 32'hDEAD_BEEF;
        last_cyc = 0;
        req0 = 1'b1; we0 = 1'b0; addr0 = a[0]; wdata0 = '0;
        exp_g.push_back(gexp_t'{port: 1'b0, we: 1'b0, addr: a[0], wdata: '0});
        exp_r.push_back(rexp_t'{port: 1'b0, data: d[0]});
        for (int k = 0; k < 3; k++) begin
            wait_gnt(p);
            req0 = 1'b0;
            total++;
            if (p != 0) begin bad++; $display("FAIL b2b_gnt[%0d]: port=%0d, required 0", k, p); end
            if (k > 0) begin
                total++;
                if (cyc - last_cyc != int'(LAT) + 2) begin
                    bad++;
                    $display("FAIL b2b_period[%0d]: %0d cycles, required %0d", k, cyc - last_cyc, LAT + 2);
                end
            end
            last_cyc = cyc;
            n = -1;
            for (int i = 1; i <= TMO; i++) begin
                @(posedge clk); #1;
                if (rvalid0) begin n = i; break; end
            end
            total++;
            if (n != int'(LAT) + 1 || rdata0 !== d[k]) begin
                bad++;
                $display("FAIL b2b_read[%0d]: latency=%0d rdata0=%h, required %0d %h", k, n, rdata0, LAT + 1, d[k]);
            end
            if (k < 2) begin
                req0 = 1'b1; addr0 = a[k+1];
                exp_g.push_back(gexp_t'{port: 1'b0, we: 1'b0, addr: a[k+1], wdata: '0});
                exp_r.push_back(rexp_t'{port: 1'b0, data: d[k+1]});
            end
        end
        idle_inputs();
    endtask

    task automatic test_single_read();
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h40; wdata1 = '0;
        exp_g.push_back(gexp_t'{port: 1'b1, we: 1'b0, addr: 32'h40, wdata: '0});
        exp_r.push_back(rexp_t'{port: 1'b1, data: 32'h1234_5678});
        @(posedge clk); #1;
        req1 = 1'b0;
        total++;
        if ({gnt1, gnt0} !== 2'b10) begin bad++; $display("FAIL read_gnt1: gnt=%b%b, required 10", gnt1, gnt0); end
        for (int c = 2; c <= int'(LAT) + 1; c++) begin
            @(posedge clk); #1;
            total++;
            if ({rvalid1, busy, mem_en} !== 3'b010) begin
                bad++;
                $display("FAIL read_wait[%0d]: rvalid1=%b busy=%b mem_en=%b, required 0 1 0", c, rvalid1, busy, mem_en);
            end
        end
        @(posedge clk); #1;
        total++;
        if ({rvalid1, busy, rdata1} !== {2'b10, 32'h1234_5678}) begin
            bad++;
            $display("FAIL read_data: rvalid1=%b busy=%b rdata1=%h, required 1 0 12345678", rvalid1, busy, rdata1);
        end
        @(posedge clk); #1;
        total++;
        if ({rvalid1, rdata1, rdata0} !== {1'b0, 32'h1234_5678, 32'hDEAD_BEEF}) begin
            bad++;
            $display("FAIL read_hold: rvalid1=%b rdata1=%h rdata0=%h, required 0 12345678 deadbeef", rvalid1, rdata1, rdata0);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem_model[i] = 32'hC0DE_0000 | 32'(i);
        mem_model[16] = 32'h1234_5678;
        idle_inputs();
        test_reset();
        test_tie();
        test_single_write();
        test_back_to_back();
        test_single_read();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (exp_g.size() != 0 || exp_r.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: grants left=%0d reads left=%0d, required 0 0", exp_g.size(), exp_r.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
